// File: rtl/mdu_seq_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: op encodings,
// FSM state encodings and the M-extension funct7 decode constant.
package mdu_seq_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_FIX  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_e;

  // funct7 value the decoder matches to route OP-class instructions here
  localparam logic [6:0] MDU_INST_M_FUNCT7 = 7'b0000001;

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  function automatic logic src1_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic src2_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: sign-magnitude operand capture, one shift-add or
// restoring-divide step per strobe, and final select/negate into result_o.
module mdu_iter_core
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic            special_i,
  input  logic [XLEN-1:0] special_res_i,
  input  mdu_op_e         op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [XLEN-1:0] result_o
);

  mdu_op_e           op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              s1_neg, s2_neg;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     sum, shifted, trial;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem;

  // acc holds {hi, multiplier} for multiplies and {remainder, quotient} for divides
  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;

    s1_neg  = src1_signed(op_i) & src1_i[XLEN-1];
    s2_neg  = src2_signed(op_i) & src2_i[XLEN-1];
    abs1    = s1_neg ? -src1_i : src1_i;
    abs2    = s2_neg ? -src2_i : src2_i;
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    trial   = shifted - {1'b0, opb_q};
    prod_s  = neg_q ? -acc_q : acc_q;
    quo     = acc_q[XLEN-1:0];
    rem     = acc_q[2*XLEN-1:XLEN];

    if (load_i) begin
      op_d  = op_i;
      acc_d = {{XLEN{1'b0}}, abs1};
      opb_d = abs2;
      case (op_i)
        MDU_MUL: neg_d = 1'b0;
        MDU_REM: neg_d = s1_neg;
        default: neg_d = s1_neg ^ s2_neg;
      endcase
    end else if (step_i) begin
      if (op_is_div(op_q)) begin
        if (!trial[XLEN]) acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else              acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {sum, acc_q[XLEN-1:1]};
      end
    end else if (fix_i) begin
      case (op_q)
        MDU_MUL:                        result_d = acc_q[XLEN-1:0];
        MDU_MULH, MDU_MULHSU, MDU_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
        MDU_DIV, MDU_DIVU:              result_d = neg_q ? -quo : quo;
        default:                        result_d = neg_q ? -rem : rem;
      endcase
    end

    if (special_i) result_d = special_res_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q     <= MDU_MUL;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/mdu_seq.sv
// EX-stage multiply/divide sequencer: accepts an op, stalls the pipe while
// the iterative core runs, pulses done_valid_o with the result, obeys flush.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [4:0]      w_reg_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      w_reg_addr_o
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       rd_q, rd_d;

  mdu_op_e          op;
  logic             src2_zero, sgn_ovf, is_special;
  logic [XLEN-1:0]  special_res;
  logic             load, step, fix, special;

  assign op        = mdu_op_e'(op_i);
  assign src2_zero = (src2_i == '0);
  assign sgn_ovf   = (op == MDU_DIV || op == MDU_REM) &&
                     (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
  assign is_special = op_is_div(op) && (src2_zero || sgn_ovf);

  always_comb begin
    if (src2_zero)          special_res = op_is_rem(op) ? src1_i : '1;
    else if (op == MDU_DIV) special_res = {1'b1, {(XLEN-1){1'b0}}};
    else                    special_res = '0;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    special = 1'b0;
    case (state_q)
      MDU_ST_IDLE: begin
        if (req_valid_i && !flush_i) begin
          load    = 1'b1;
          rd_d    = w_reg_addr_i;
          count_d = '0;
          if (is_special) begin
            special = 1'b1;
            state_d = MDU_ST_DONE;
          end else begin
            state_d = MDU_ST_CALC;
          end
        end
      end
      MDU_ST_CALC: begin
        step    = 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(XLEN-1)) state_d = MDU_ST_FIX;
      end
      MDU_ST_FIX: begin
        fix     = 1'b1;
        state_d = MDU_ST_DONE;
      end
      default: state_d = MDU_ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = MDU_ST_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= MDU_ST_IDLE;
      count_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
    end
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .load_i        (load),
    .step_i        (step),
    .fix_i         (fix),
    .special_i     (special),
    .special_res_i (special_res),
    .op_i          (op),
    .src1_i        (src1_i),
    .src2_i        (src2_i),
    .result_o      (result_o)
  );

  // rst_n_i gating keeps every output low while reset is held
  assign stall_o      = rst_n_i & req_valid_i & (state_q != MDU_ST_DONE) & ~flush_i;
  assign busy_o       = (state_q != MDU_ST_IDLE);
  assign done_valid_o = (state_q == MDU_ST_DONE) & ~flush_i;
  assign w_reg_addr_o = rd_q;

endmodule
